// File: rtl/ps2_controller.sv
// rtl/ps2_controller.sv - PS/2 keyboard receiver bus slave with scan-code FIFO
// Define PS2_IRQ_EN to enable the data-available interrupt and the CTRL irq_en bit.
module ps2_controller #(
  parameter int A_WIDTH    = 32,
  parameter int D_WIDTH    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic               clk50MHz,
  input  logic               reset,
  input  logic [A_WIDTH-1:0] baddr,
  input  logic               bwe,
  input  logic               benable,
  input  logic [D_WIDTH-1:0] bus_data_in,
  output logic [D_WIDTH-1:0] bus_data_out,
  output logic               bwait,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  output logic               irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {B_IDLE, B_BUSY, B_DONE} bus_state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, filt_hit, strobe;
  logic [FW-1:0] filt_cnt;

  rx_state_t     rx_state;
  logic [7:0]    rx_shift;
  logic          rx_par;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic          rx_timeout, stop_seen, par_good, push, push_ok;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, full, pop, flush, clr, ctrl_wr;
  logic          overflow, frame_err, parity_err, irq_en;

  bus_state_t        bus_state;
  logic [D_WIDTH-1:0] rd_val;
  logic               unused_bits;

  assign unused_bits = ^{baddr[A_WIDTH-1:2], bus_data_in[D_WIDTH-1:2]};

  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1; clk_s2 <= 1'b1;
      dat_s1 <= 1'b1; dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;  clk_s2 <= clk_s1;
      dat_s1 <= ps2_data; dat_s2 <= dat_s1;
    end
  end

  // The strobe fires on the cycle the filtered clock is about to fall.
  assign filt_hit = (clk_s2 != filt_clk) && (filt_cnt == FW'(FILTER_LEN - 1));
  assign strobe   = filt_hit && !clk_s2;

  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_hit) begin
      filt_clk <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign rx_timeout = (rx_state != RX_IDLE) && (to_cnt == TW'(TIMEOUT));
  assign stop_seen  = strobe && (rx_state == RX_STOP);
  assign par_good   = ^{rx_shift, rx_par};
  assign push       = stop_seen && dat_s2 && par_good;
  assign push_ok    = push && !full;

  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_shift <= '0;
      rx_par   <= 1'b0;
      bit_cnt  <= '0;
      to_cnt   <= '0;
    end else begin
      if (strobe || rx_state == RX_IDLE) to_cnt <= '0;
      else                               to_cnt <= to_cnt + 1'b1;
      if (rx_timeout) begin
        rx_state <= RX_IDLE;
      end else if (strobe) begin
        unique case (rx_state)
          RX_IDLE: if (!dat_s2) begin
            rx_state <= RX_DATA;
            bit_cnt  <= '0;
          end
          RX_DATA: begin
            rx_shift <= {dat_s2, rx_shift[7:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) rx_state <= RX_PARITY;
          end
          RX_PARITY: begin
            rx_par   <= dat_s2;
            rx_state <= RX_STOP;
          end
          RX_STOP: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign ctrl_wr = (bus_state == B_BUSY) && bwe && (baddr[1:0] == 2'd2);
  assign pop     = (bus_state == B_BUSY) && !bwe && (baddr[1:0] == 2'd0) && !empty;
  assign flush   = ctrl_wr && bus_data_in[1];
  assign clr     = ctrl_wr && bus_data_in[0];

  always_ff @(posedge clk50MHz) begin
    if (push_ok) mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  // Error sets take priority over a same-cycle clear.
  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) begin
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (push && full)                          overflow   <= 1'b1;
      else if (clr)                              overflow   <= 1'b0;
      if ((stop_seen && !dat_s2) || rx_timeout)  frame_err  <= 1'b1;
      else if (clr)                              frame_err  <= 1'b0;
      if (stop_seen && !par_good)                parity_err <= 1'b1;
      else if (clr)                              parity_err <= 1'b0;
    end
  end

`ifdef PS2_IRQ_EN
  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= bus_data_in[2];
      irq <= irq_en && !empty;
    end
  end
`else
  assign irq_en = 1'b0;
  assign irq    = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    unique case (baddr[1:0])
      2'd0: if (!empty) rd_val[8:0] = {1'b1, mem[rd_ptr]};
      2'd1: rd_val[CW+4:0] = {overflow, frame_err, parity_err, full, empty, count};
      2'd2: rd_val[2] = irq_en;
      default: ;
    endcase
  end

  always_ff @(posedge clk50MHz or posedge reset) begin
    if (reset) begin
      bus_state    <= B_IDLE;
      bwait        <= 1'b0;
      bus_data_out <= '0;
    end else begin
      unique case (bus_state)
        B_IDLE: if (benable) begin
          bus_state <= B_BUSY;
          bwait     <= 1'b1;
        end
        B_BUSY: begin
          bus_state    <= B_DONE;
          bwait        <= 1'b0;
          bus_data_out <= bwe ? '0 : rd_val;
        end
        B_DONE: if (!benable) begin
          bus_state    <= B_IDLE;
          bus_data_out <= '0;
        end
        default: bus_state <= B_IDLE;
      endcase
    end
  end
endmodule

// File: doc/ps2_controller.md
# ps2_controller

PS/2 keyboard receiver exposed as a bus slave at bus ID 3 (PS2). Deserialises PS/2 device-to-host frames, checks them, and buffers scan codes in a FIFO. The CPU reads them through the bus controller; the block's `bus_data_out` feeds input 3 of the bus data mux.

## Interface
- `A_WIDTH`, 32: physical bus address width.
- `D_WIDTH`, 16: bus data width.
- `FIFO_DEPTH`, 8: scan-code FIFO entries; must be a power of 2, at least 2.
- `FILTER_LEN`, 8: cycles the synchronised `ps2_clk` must be stable before a level change is accepted.
- `TIMEOUT`, 50000: idle cycles mid-frame before abort (1 ms at 50 MHz).

Ports:
- `clk50MHz`  in  1: system clock; all logic on its rising edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `baddr`  in  A_WIDTH: physical address; only `baddr[1:0]` is decoded.
- `bwe`  in  1: 1 = write access, 0 = read.
- `benable`  in  1: device select from the bus controller.
- `bus_data_in`  in  D_WIDTH: write data.
- `bus_data_out`  out  D_WIDTH: read data; 0 whenever not in DONE.
- `bwait`  out  1: access in progress.
- `ps2_clk`  in  1: PS/2 clock pad, asynchronous.
- `ps2_data`  in  1: PS/2 data pad, asynchronous.
- `irq`  out  1: data-available interrupt.

## Operation
- Input conditioning:
  - 2-flop synchronisers on `ps2_clk` and `ps2_data`.
  - The filtered clock changes only after the synchronised value has differed for FILTER_LEN consecutive cycles.
  - A falling edge of the filtered clock is the sample strobe; data is sampled on the strobe cycle.
- RX FSM: RX_IDLE → RX_DATA → RX_PARITY → RX_STOP → RX_IDLE.
  - RX_IDLE: on a strobe with data=0 (start bit), go to RX_DATA. A strobe with data=1 is ignored.
  - RX_DATA: shift 8 bits, LSB first; a 3-bit counter selects RX_PARITY after bit 7.
  - RX_PARITY: capture the parity bit. Odd parity is required: XOR of the 8 data bits and parity = 1.
  - RX_STOP, outcome by case:
    - stop=1 and parity good: push the byte.
    - parity bad: set `parity_err`, discard the byte.
    - stop=0: set `frame_err`, discard the byte.
  - The timeout counter resets on every strobe. In any state other than RX_IDLE, reaching TIMEOUT sets `frame_err` and forces RX_IDLE.
- FIFO:
  - Push when full: drop the new byte and set `overflow`.
  - Push and pop in the same cycle: both take effect and count is unchanged; a pop of an empty FIFO does not pop the simultaneous push.
  - Pointers wrap modulo FIFO_DEPTH; `count` is $clog2(FIFO_DEPTH)+1 bits wide.
- Register map, by `baddr[1:0]`:
  - 0 DATA (read): returns {7'b0, valid, byte} and pops one entry. An empty FIFO returns 0 and does not pop. Writes are ignored.
  - 1 STATUS (read): returns {overflow, frame_err, parity_err, full, empty, count}, zero-extended. Writes are ignored.
  - 2 CTRL (write):
    - bit0: clear all three error flags.
    - bit1: flush the FIFO.
    - bit2: `irq_en`.
    - A read returns {13'b0, irq_en, 2'b0}.
  - 3: reads 0; writes ignored.
  - Flag clear loses to a same-cycle error set: the flag stays set.
- Bus FSM: IDLE → BUSY → DONE → IDLE.
  - IDLE: `benable`=1 → BUSY.
  - BUSY (exactly one cycle):
    - Read: capture the read data and perform the pop.
    - Write: apply CTRL.
  - DONE: stays until `benable`=0, then IDLE. Exactly one pop or write occurs per access, however long `benable` is held.

## Timing
- Reset values:
  - Outputs: `bus_data_out`=0, `bwait`=0, `irq`=0.
  - FIFO empty, all flags 0, `irq_en`=0.
  - Both FSMs in their idle state; filtered clock 1.
- Bus: `benable` first seen high at edge N.
  - `bwait`=1 during N+1 (BUSY).
  - At N+2 (DONE): `bwait`=0 and `bus_data_out` valid, held until `benable` falls.
  - Read latency: 2 cycles.
- RX: a byte is visible in `count` 1 cycle after the stop-bit strobe.
- Pad-to-strobe latency: 2 + FILTER_LEN cycles.
- A FIFO flush in the same cycle as a push leaves the FIFO empty.
- Reset mid-frame or mid-access aborts the frame or access immediately; there is no partial push.

## Configuration
- `PS2_IRQ_EN` defined: `irq` = `irq_en` & !empty, registered, 1-cycle latency.
- `PS2_IRQ_EN` undefined:
  - `irq` tied to 0.
  - CTRL bit2 is not stored and reads 0.
  - The port remains present.

## Test plan
- Frame 0x1C with parity 0 and stop 1; then read addr 0 → `bus_data_out`=0x011C at N+2, `bwait` high only at N+1, then STATUS `empty`=1.
- Frame 0x1C with parity 1 → STATUS `parity_err`=1, `count`=0; CTRL write 0x1 → flag cleared.
- 9 valid frames, FIFO_DEPTH=8 → `full`=1, `overflow`=1; 8 reads return bytes 1..8 in order; 9th read returns 0x0000.
- Frame with start bit then 3 data bits, then idle 50000 cycles → `frame_err`=1, RX returns to idle; next valid 0xF0 received correctly.
- With `PS2_IRQ_EN` and CTRL=0x4, one frame → `irq`=1; read pops → `irq`=0; `benable` held 20 cycles → exactly one pop.
- Glitch on `ps2_clk` low for 3 cycles (FILTER_LEN=8) → no strobe; assert `reset` mid-frame → all outputs 0, FIFO empty.
